// File: rtl/pe_out_sched_pkg.sv
// Shared definitions for the PE output scheduler: packet field layout,
// bag (TYPE) codes, FSM state encoding and a packet assembly helper.
package pe_out_sched_pkg;

  localparam int PKT_W  = 40;
  localparam int ID_W   = 4;
  localparam int TIME_W = 10;
  localparam int DATA_W = 20;
  localparam int TYPE_W = 2;

  localparam int TYPE_MIN = 0;
  localparam int TYPE_MAX = 1;
  localparam int DATA_MIN = 2;
  localparam int DATA_MAX = 21;
  localparam int TIME_MIN = 22;
  localparam int TIME_MAX = 31;
  localparam int DST_MIN  = 32;
  localparam int DST_MAX  = 35;
  localparam int SRC_MIN  = 36;
  localparam int SRC_MAX  = 39;

  localparam logic [TYPE_W-1:0] BAG_NOR = 2'b01;
  localparam logic [TYPE_W-1:0] BAG_REQ = 2'b10;
  localparam logic [TYPE_W-1:0] BAG_RET = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_RET = 3'd1,
    SEND_REQ = 3'd2,
    SEND_NOR = 3'd3,
    GAP      = 3'd4
  } state_t;

  // Assemble a control packet from its fields.
  function automatic logic [PKT_W-1:0] mk_pkt(input logic [ID_W-1:0]   src,
                                               input logic [ID_W-1:0]   dst,
                                               input logic [TIME_W-1:0] tm,
                                               input logic [DATA_W-1:0] data,
                                               input logic [TYPE_W-1:0] bag);
    logic [PKT_W-1:0] p;
    p = '0;
    p[SRC_MAX:SRC_MIN]   = src;
    p[DST_MAX:DST_MIN]   = dst;
    p[TIME_MAX:TIME_MIN] = tm;
    p[DATA_MAX:DATA_MIN] = data;
    p[TYPE_MAX:TYPE_MIN] = bag;
    return p;
  endfunction

endpackage

// File: rtl/pe_out_sched_if.sv
// Normal-packet source and router injection handshake bundle.
// master: the scheduler side; slave: the PE/router environment side.
interface pe_out_sched_if;
  import pe_out_sched_pkg::*;

  logic             norm_valid;
  logic [PKT_W-1:0] norm_data;
  logic             norm_ready;
  logic [PKT_W-1:0] data_p2r;
  logic             valid_p2r;
  logic             ready_p2r;

  modport master (
    input  norm_valid, norm_data, ready_p2r,
    output norm_ready, data_p2r, valid_p2r
  );

  modport slave (
    output norm_valid, norm_data, ready_p2r,
    input  norm_ready, data_p2r, valid_p2r
  );
endinterface

// File: rtl/pe_out_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_TAR.
module rr_pick #(
  parameter  int NUM_TAR = 4,
  localparam int IW      = (NUM_TAR > 1) ? $clog2(NUM_TAR) : 1
) (
  input  logic [NUM_TAR-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      grant,
  output logic               any
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest set slot wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NUM_TAR - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_TAR);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_out_sched.sv
// Per-PE output scheduler: shares the PE->router injection port between
// normal, retransmission-request and retransmission packets.
// Optional statistics counters: define PE_OUT_SCHED_STATS_EN.
module pe_out_sched
  import pe_out_sched_pkg::*;
#(
  parameter logic [ID_W-1:0]   MY_ID      = 4'b0000,
  parameter int                NUM_TAR    = 4,
  parameter int                CTRL_BURST = 4,
  parameter logic [TYPE_W-1:0] REQ_BAG    = BAG_REQ,
  parameter logic [TYPE_W-1:0] RET_BAG    = BAG_RET
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_TAR*ID_W-1:0]   tar_id,
  input  logic [NUM_TAR-1:0]        req_pend,
  input  logic [NUM_TAR*DATA_W-1:0] diff_cnt,
  input  logic [NUM_TAR*DATA_W-1:0] ret_cnt,
  pe_out_sched_if.master            bus,
  output logic                      request_out_flag,
  output logic [ID_W-1:0]           request_dst,
  output logic                      retrans_out_flag,
  output logic [ID_W-1:0]           retrans_dst,
  output logic                      hold_out_flag
`ifdef PE_OUT_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_nor,
  output logic [15:0]               stat_req,
  output logic [15:0]               stat_ret,
  output logic [15:0]               stat_stall
`endif
);

  localparam int            IW        = (NUM_TAR > 1) ? $clog2(NUM_TAR) : 1;
  localparam int            BW        = $clog2(CTRL_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CTRL_BURST);

  logic [ID_W-1:0]   tid_a  [NUM_TAR];
  logic [DATA_W-1:0] diff_a [NUM_TAR];
  logic [DATA_W-1:0] ret_a  [NUM_TAR];
  logic [NUM_TAR-1:0] ret_nz;

  for (genvar i = 0; i < NUM_TAR; i++) begin : g_slot
    assign tid_a[i]  = tar_id[i*ID_W +: ID_W];
    assign diff_a[i] = diff_cnt[i*DATA_W +: DATA_W];
    assign ret_a[i]  = ret_cnt[i*DATA_W +: DATA_W];
    assign ret_nz[i] = |ret_a[i];
  end

  state_t        state;
  state_t        pick;
  logic [IW-1:0] ret_ptr, req_ptr, cur_slot;
  logic [IW-1:0] ret_idx, req_idx;
  logic          ret_any, req_any;
  logic [BW-1:0] burst_cnt;
  logic [TIME_W-1:0] time_cnt;

  rr_pick #(.NUM_TAR(NUM_TAR)) u_ret_pick (
    .req   (ret_nz),
    .ptr   (ret_ptr),
    .grant (ret_idx),
    .any   (ret_any)
  );

  rr_pick #(.NUM_TAR(NUM_TAR)) u_req_pick (
    .req   (req_pend),
    .ptr   (req_ptr),
    .grant (req_idx),
    .any   (req_any)
  );

  function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] s);
    if (int'(s) == NUM_TAR - 1) return '0;
    return s + IW'(1);
  endfunction

  // Launch decision in IDLE: starved normal first, then retrans, request, normal.
  always_comb begin
    pick = IDLE;
    if (state == IDLE && enable && rst_n) begin
      if (bus.norm_valid && burst_cnt == BURST_MAX) pick = SEND_NOR;
      else if (ret_any)                             pick = SEND_RET;
      else if (req_any)                             pick = SEND_REQ;
      else if (bus.norm_valid)                      pick = SEND_NOR;
    end
  end

  assign bus.norm_ready = (pick == SEND_NOR);
  assign hold_out_flag  = bus.valid_p2r & ~bus.ready_p2r;

  // Scheduler FSM with registered packet, valid, flags, pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.data_p2r     <= '0;
      bus.valid_p2r    <= 1'b0;
      request_out_flag <= 1'b0;
      request_dst      <= '0;
      retrans_out_flag <= 1'b0;
      retrans_dst      <= '0;
      cur_slot         <= '0;
      ret_ptr          <= '0;
      req_ptr          <= '0;
      burst_cnt        <= '0;
      time_cnt         <= '0;
    end else begin
      if (enable) time_cnt <= time_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (!bus.norm_valid) burst_cnt <= '0;
          unique case (pick)
            SEND_RET: begin
              state            <= SEND_RET;
              cur_slot         <= ret_idx;
              bus.data_p2r     <= mk_pkt(MY_ID, tid_a[ret_idx], time_cnt, ret_a[ret_idx], RET_BAG);
              bus.valid_p2r    <= 1'b1;
              retrans_out_flag <= 1'b1;
              retrans_dst      <= tid_a[ret_idx];
            end
            SEND_REQ: begin
              state            <= SEND_REQ;
              cur_slot         <= req_idx;
              bus.data_p2r     <= mk_pkt(MY_ID, tid_a[req_idx], time_cnt, diff_a[req_idx], REQ_BAG);
              bus.valid_p2r    <= 1'b1;
              request_out_flag <= 1'b1;
              request_dst      <= tid_a[req_idx];
            end
            SEND_NOR: begin
              state         <= SEND_NOR;
              bus.data_p2r  <= bus.norm_data;
              bus.valid_p2r <= 1'b1;
            end
            default: ;
          endcase
        end
        SEND_RET, SEND_REQ, SEND_NOR: begin
          if (bus.ready_p2r) begin
            state            <= GAP;
            bus.valid_p2r    <= 1'b0;
            request_out_flag <= 1'b0;
            request_dst      <= '0;
            retrans_out_flag <= 1'b0;
            retrans_dst      <= '0;
            if (state == SEND_RET) ret_ptr <= next_slot(cur_slot);
            if (state == SEND_REQ) req_ptr <= next_slot(cur_slot);
            if (state == SEND_NOR)
              burst_cnt <= '0;
            else if (bus.norm_valid && burst_cnt != BURST_MAX)
              burst_cnt <= burst_cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_OUT_SCHED_STATS_EN
  // Accepted-packet counters per type (wrapping) and stall counter (saturating).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_nor   <= '0;
      stat_req   <= '0;
      stat_ret   <= '0;
      stat_stall <= '0;
    end else begin
      if (bus.valid_p2r && bus.ready_p2r) begin
        if (state == SEND_NOR) stat_nor <= stat_nor + 1'b1;
        if (state == SEND_REQ) stat_req <= stat_req + 1'b1;
        if (state == SEND_RET) stat_ret <= stat_ret + 1'b1;
      end
      if (hold_out_flag && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
